tm1638_responder: RTL
=====================

Name: tm1638_responder

Overview:
- Device-side model of the TM1638 serial interface: the chip end of the STB/CLK/DIO link that the LED&KEY host driver controls.
- Decodes data, address and display-control commands, and maintains a 16-byte display RAM plus display on/off and brightness state.
- Answers key-read commands by shifting out 4 key-scan bytes on DIO.
- Used as an on-FPGA emulator and as the bus-functional target in host-driver testbenches.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on the STB/CLK/DIO inputs (minimum 2).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous reset, active low.
- i_tm1638_clk  in  1  serial clock from the host.
- i_tm1638_stb  in  1  strobe from the host; active low, frames a transaction.
- io_tm1638_data  inout  1  DIO line; driven only during key read, otherwise high-Z.
- i_key_data  in  32  key-scan bytes; byte0 = [7:0] is sent first.
- o_display_ram  out  128  display RAM; address a is held in [8a+7:8a].
- o_ram_we  out  1  one-cycle pulse for each RAM byte written.
- o_ram_addr  out  4  address of that write.
- o_ram_data  out  8  data of that write.
- o_display_on  out  1  display enable (bit3 of the display-control command).
- o_brightness  out  3  brightness (bits2:0 of the display-control command).
- o_auto_inc  out  1  current addressing mode; 1 = auto-increment.
- o_read_mode  out  1  current data-command direction; 1 = key read.
- o_frame_err  out  1  one-cycle pulse on a protocol error.
- o_idle  out  1  high while STB is high and DIO is released.

Behaviour:
- Reset (i_rst_n low at a clk edge):
  - RAM cleared to all zeros.
  - o_display_on=0, o_brightness=0, o_auto_inc=1, o_read_mode=0.
  - DIO released; o_ram_we=0, o_frame_err=0; state S_IDLE.
  - Reset asserted mid-frame aborts the frame with no RAM write.
- Input conditioning:
  - STB, CLK and DIO each pass through a SYNC_STAGES synchroniser followed by an edge detector.
  - Required ratio: every CLK high or low phase lasts at least SYNC_STAGES+1 i_clk cycles.
- Bit order: LSB first in both directions.
  - Host-to-device bits are sampled on synced CLK rising edges.
  - Device-to-host bits are updated on synced CLK falling edges.
- Bit counter is 3 bits; a byte is complete on the 8th rising edge.
- States:
  - S_IDLE: wait for STB fall, then clear the bit counter and go to S_CMD.
  - S_CMD: receive the first byte, decoded on bits[7:6]:
    - 01 = data command. Set o_read_mode=bit1 and o_auto_inc=!bit2 (both persist across frames). If bit1=1, latch i_key_data and go to S_RDATA; otherwise go to S_IGNORE.
    - 10 = display control. Update o_display_on and o_brightness, then go to S_IGNORE.
    - 11 = address command. Load the address pointer from bits3:0, then go to S_WDATA.
    - 00 = invalid. Pulse o_frame_err, then go to S_IGNORE.
  - S_WDATA: each completed byte is written at the pointer.
    - o_ram_we, o_ram_addr and o_ram_data are valid 1 cycle after the completing edge is detected.
    - o_display_ram updates on the same cycle as o_ram_we.
    - If o_auto_inc, the pointer increments with 4-bit wrap (15 -> 0); otherwise it is fixed.
  - S_RDATA:
    - First synced CLK fall after the command byte: drive bit0 of byte0.
    - Each further fall advances one bit, 32 bits in total.
    - After bit 31 the device releases DIO (bus reads 1 via pull-up); further clocks are ignored.
    - Received DIO bits are ignored while in read.
  - S_IGNORE: discard all clocks until STB rises.
- Driving DIO: open-drain style. A 0 bit drives low; a 1 bit releases the line.
- STB rise in any state:
  - Release DIO and return to S_IDLE; the pointer is discarded.
  - If the bit counter is nonzero (partial byte), pulse o_frame_err and drop the partial byte.
  - A STB rise between whole bytes is legal.
- Simultaneous STB rise and CLK edge in the same cycle: STB wins and the edge is ignored.
- An address command with zero data bytes is legal: no write, no error.
- o_idle = (state==S_IDLE) && synced STB high.

Decomposition:
- tm1638_pkg holds:
  - the command field constants: CMD_DATA=2'b01, CMD_DISP=2'b10, CMD_ADDR=2'b11;
  - data-command bit positions: RD_BIT=1, FIX_BIT=2;
  - the DISP_ON bit (bit 3);
  - the state enum.
- tm1638_sync_edge: sub-module of SYNC_STAGES flops with outputs o_level, o_rise, o_fall; instantiated once each for STB, CLK and DIO.

Test Plan:
- Frame 0x40, then frame 0xC0 followed by 16 bytes 0x00..0x0F -> ram[a]=a for all a; 16 o_ram_we pulses; o_auto_inc=1.
- Frame 0x44, then frame 0xC5,0xAA,0xBB -> ram[5]=0xBB (fixed address); other bytes unchanged; 2 we pulses, both to addr 5.
- Frame 0x40, then 0xCF,0x11,0x22 -> ram[15]=0x11, ram[0]=0x22 (pointer wrap).
- Frame 0x8A -> o_display_on=1, o_brightness=2. Frame 0x80 -> o_display_on=0.
- i_key_data=0x04030201; frame 0x42 plus 32 host clocks -> host samples bytes 0x01,0x02,0x03,0x04 in that order. DIO is high-Z after the 32nd bit and after STB rises.
- Aborts:
  - STB rises after 5 bits of a data byte -> o_frame_err pulse, no RAM write.
  - First byte 0x3F -> o_frame_err pulse.
  - i_rst_n low during key read -> DIO released and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared constants and state encoding for the TM1638 device-side responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tm1638_pkg;

    localparam int RAM_BYTES = 16;
    localparam int KEY_BITS  = 32;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int RD_BIT  = 1;
    localparam int FIX_BIT = 2;
    localparam int DISP_ON = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

endpackage

// File: rtl/tm1638_responder_if.sv
// Host-side strobe/clock/key inputs and display-state outputs of the responder.
// Latency: n/a (wiring only).
// Backpressure: none; the serial host paces every transfer.
interface tm1638_responder_if;
    import tm1638_pkg::*;

    logic                     tm1638_clk;
    logic                     tm1638_stb;
    logic [KEY_BITS-1:0]      key_data;
    logic [8*RAM_BYTES-1:0]   display_ram;
    logic                     ram_we;
    logic [3:0]               ram_addr;
    logic [7:0]               ram_data;
    logic                     display_on;
    logic [2:0]               brightness;
    logic                     auto_inc;
    logic                     read_mode;
    logic                     frame_err;
    logic                     idle;

    modport master (
        output tm1638_clk, tm1638_stb, key_data,
        input  display_ram, ram_we, ram_addr, ram_data, display_on,
               brightness, auto_inc, read_mode, frame_err, idle
    );

    modport slave (
        input  tm1638_clk, tm1638_stb, key_data,
        output display_ram, ram_we, ram_addr, ram_data, display_on,
               brightness, auto_inc, read_mode, frame_err, idle
    );

endinterface

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection for one asynchronous input.
// Latency: STAGES cycles to o_level, edges flagged for one cycle as o_level changes.
// Backpressure: none.
module tm1638_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_rise  = o_level & ~prev_q;
    assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 chip-side model: decodes STB/CLK/DIO frames into display RAM/control state, shifts key bytes out.
// Latency: RAM write and status appear 1 cycle after the synced CLK edge that completes a byte.
// Backpressure: none; host must hold each CLK phase >= SYNC_STAGES+1 cycles.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    inout  wire                 io_tm1638_data,
    tm1638_responder_if.slave   bus
);

    logic stb_lvl, stb_rise, stb_fall;
    logic clk_lvl, clk_rise, clk_fall;
    logic dio_lvl, dio_rise, dio_fall;

    tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_stb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.tm1638_stb),
        .o_level(stb_lvl), .o_rise(stb_rise), .o_fall(stb_fall)
    );
    tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.tm1638_clk),
        .o_level(clk_lvl), .o_rise(clk_rise), .o_fall(clk_fall)
    );
    tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dio (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(io_tm1638_data),
        .o_level(dio_lvl), .o_rise(dio_rise), .o_fall(dio_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, clk_lvl, dio_rise, dio_fall};

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shreg_q, shreg_d;
    logic [3:0]             ptr_q, ptr_d;
    logic [KEY_BITS-1:0]    key_sr_q, key_sr_d;
    logic [5:0]             rd_cnt_q, rd_cnt_d;
    logic                   dio_low_q, dio_low_d;
    logic [8*RAM_BYTES-1:0] ram_q, ram_d;
    logic                   we_q, we_d;
    logic [3:0]             waddr_q, waddr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   disp_on_q, disp_on_d;
    logic [2:0]             bright_q, bright_d;
    logic                   auto_inc_q, auto_inc_d;
    logic                   read_mode_q, read_mode_d;
    logic                   err_q, err_d;
    logic [7:0]             byte_in;

    // LSB-first: the newest bit lands in bit 7 and the byte settles after eight shifts.
    assign byte_in = {dio_lvl, shreg_q};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            ptr_q       <= '0;
            key_sr_q    <= '0;
            rd_cnt_q    <= '0;
            dio_low_q   <= 1'b0;
            ram_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            disp_on_q   <= 1'b0;
            bright_q    <= '0;
            auto_inc_q  <= 1'b1;
            read_mode_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            key_sr_q    <= key_sr_d;
            rd_cnt_q    <= rd_cnt_d;
            dio_low_q   <= dio_low_d;
            ram_q       <= ram_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            disp_on_q   <= disp_on_d;
            bright_q    <= bright_d;
            auto_inc_q  <= auto_inc_d;
            read_mode_q <= read_mode_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        key_sr_d    = key_sr_q;
        rd_cnt_d    = rd_cnt_q;
        dio_low_d   = dio_low_q;
        ram_d       = ram_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        disp_on_d   = disp_on_q;
        bright_d    = bright_q;
        auto_inc_d  = auto_inc_q;
        read_mode_d = read_mode_q;
        err_d       = 1'b0;

        // STB rise outranks any CLK edge seen in the same cycle.
        if (stb_rise) begin
            state_d   = S_IDLE;
            dio_low_d = 1'b0;
            bit_cnt_d = '0;
            err_d     = (bit_cnt_q != 3'd0);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stb_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = '0;
                    end
                end
                S_CMD: begin
                    if (clk_rise) begin
                        shreg_d   = byte_in[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (byte_in[7:6])
                                CMD_DATA: begin
                                    read_mode_d = byte_in[RD_BIT];
                                    auto_inc_d  = ~byte_in[FIX_BIT];
                                    if (byte_in[RD_BIT]) begin
                                        key_sr_d = bus.key_data;
                                        rd_cnt_d = '0;
                                        state_d  = S_RDATA;
                                    end else begin
                                        state_d  = S_IGNORE;
                                    end
                                end
                                CMD_DISP: begin
                                    disp_on_d = byte_in[DISP_ON];
                                    bright_d  = byte_in[2:0];
                                    state_d   = S_IGNORE;
                                end
                                CMD_ADDR: begin
                                    ptr_d   = byte_in[3:0];
                                    state_d = S_WDATA;
                                end
                                default: begin
                                    err_d   = 1'b1;
                                    state_d = S_IGNORE;
                                end
                            endcase
                        end
                    end
                end
                S_WDATA: begin
                    if (clk_rise) begin
                        shreg_d   = byte_in[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ram_d[{ptr_q, 3'b000} +: 8] = byte_in;
                            we_d    = 1'b1;
                            waddr_d = ptr_q;
                            wdata_d = byte_in;
                            if (auto_inc_q)
                                ptr_d = ptr_q + 4'd1;
                        end
                    end
                end
                S_RDATA: begin
                    // Release on the rise that lets the host sample bit 31.
                    if (clk_fall && rd_cnt_q != 6'd32) begin
                        dio_low_d = ~key_sr_q[0];
                        key_sr_d  = {1'b1, key_sr_q[KEY_BITS-1:1]};
                        rd_cnt_d  = rd_cnt_q + 6'd1;
                    end else if (clk_rise && rd_cnt_q == 6'd32) begin
                        dio_low_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_tm1638_data  = dio_low_q ? 1'b0 : 1'bz;

    assign bus.display_ram = ram_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_addr    = waddr_q;
    assign bus.ram_data    = wdata_q;
    assign bus.display_on  = disp_on_q;
    assign bus.brightness  = bright_q;
    assign bus.auto_inc    = auto_inc_q;
    assign bus.read_mode   = read_mode_q;
    assign bus.frame_err   = err_q;
    assign bus.idle        = (state_q == S_IDLE) && stb_lvl;

endmodule
